// File: rtl/bch_syndrome_sequencer_pkg.sv
// rtl/bch_syndrome_sequencer_pkg.sv - shared state encodings and derived constants for BCH control blocks
package bch_syndrome_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Beat counter width: max(1, clog2(beats)).
  function automatic int cnt_w_f(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

  // Only the deepest datapath needs start/data re-timed by one ce step.
  function automatic int data_dly_f(input int pipeline_stages);
    return (pipeline_stages == 2) ? 1 : 0;
  endfunction

endpackage

// File: rtl/bch_syndrome_sequencer_delay.sv
// rtl/bch_syndrome_sequencer_delay.sv - ce-qualified delay line for {start, data}
module bch_seq_delay #(
  parameter int W     = 2,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [W-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else if (ce_i) begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/bch_syndrome_sequencer.sv
// rtl/bch_syndrome_sequencer.sv - beat sequencer driving the BCH syndrome datapath controls
module bch_syndrome_sequencer
  import bch_syndrome_sequencer_pkg::*;
#(
  parameter int BITS            = 1,
  parameter int BEATS           = 8,
  parameter int PIPELINE_STAGES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  input  logic            abort,
  output logic            syn_start,
  output logic            syn_start_pipelined,
  output logic            syn_ce,
  output logic [BITS-1:0] syn_data_pipelined,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  localparam int CNT_W    = cnt_w_f(BEATS);
  localparam int DATA_DLY = data_dly_f(PIPELINE_STAGES);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(BEATS - 1);
  localparam logic [1:0]       DRAIN_LAST = 2'(PIPELINE_STAGES - 1);
  localparam state_e           LAST_STATE = (PIPELINE_STAGES > 0) ? ST_DRAIN : ST_HOLD;

  if (PIPELINE_STAGES < 0 || PIPELINE_STAGES > 2) begin : g_bad_stages
    $error("bch_syndrome_sequencer: PIPELINE_STAGES must be 0..2");
  end
  if (BEATS < 1 || BEATS > 65535) begin : g_bad_beats
    $error("bch_syndrome_sequencer: BEATS must be 1..65535");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       drain_q, drain_d;
  logic             xfer;
  logic             abort_hit;
  logic [BITS:0]    dly_d, dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // Abort outranks any simultaneous transfer, including the last beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (BEATS == 1) begin
            state_d = LAST_STATE;
            cnt_d   = '0;
          end else begin
            state_d = ST_ACCUM;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (abort_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (xfer) begin
          if (cnt_q == LAST_CNT) begin
            state_d = LAST_STATE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (abort_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          drain_d = '0;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = ST_HOLD;
          drain_d = '0;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    xfer      = in_valid && in_ready;
    abort_hit = abort && ((state_q == ST_ACCUM) || (state_q == ST_DRAIN));
    syn_ce    = rst_n && !abort_hit && (xfer || (state_q == ST_DRAIN));
    syn_start = rst_n && !abort_hit && xfer && (state_q == ST_IDLE);
    out_valid = (state_q == ST_HOLD);
    busy      = (state_q != ST_IDLE);
    dly_d     = {syn_start, (state_q == ST_DRAIN) ? {BITS{1'b0}} : in_data};
  end

  bch_seq_delay #(
    .W     (BITS + 1),
    .DEPTH (DATA_DLY)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .ce_i  (syn_ce),
    .d_i   (dly_d),
    .q_o   (dly_q)
  );

  assign syn_start_pipelined = dly_q[BITS];
  assign syn_data_pipelined  = dly_q[BITS-1:0];

endmodule

// File: tb/tb_bch_syndrome_sequencer.sv
// tb/tb_bch_syndrome_sequencer.sv - directed vector bench for bch_syndrome_sequencer
module tb_bch_syndrome_sequencer;

  typedef struct {
    logic       rst_n;
    logic       iv;
    logic [3:0] d;
    logic       ab;
    logic       ordy;
    logic       chk;
    logic [9:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready, syn_start, syn_start_p, syn_ce, out_valid, busy;
  logic [3:0] syn_data_p;

  logic       d2_iv = 1'b0, d2_ab = 1'b0, d2_or = 1'b0;
  logic [3:0] d2_d = '0;
  logic       d2_ir, d2_st, d2_stp, d2_ce, d2_ov, d2_busy;
  logic [3:0] d2_dp;

  int tests = 0;
  int failed = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  bch_syndrome_sequencer #(.BITS(4), .BEATS(4), .PIPELINE_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .abort(abort), .syn_start(syn_start), .syn_start_pipelined(syn_start_p), .syn_ce(syn_ce),
    .syn_data_pipelined(syn_data_p), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  bch_syndrome_sequencer #(.BITS(4), .BEATS(1), .PIPELINE_STAGES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_iv), .in_ready(d2_ir), .in_data(d2_d),
    .abort(d2_ab), .syn_start(d2_st), .syn_start_pipelined(d2_stp), .syn_ce(d2_ce),
    .syn_data_pipelined(d2_dp), .out_valid(d2_ov), .out_ready(d2_or), .busy(d2_busy)
  );

  function automatic vec_t mk(input int r, iv, d, ab, ordy, chk,
                              input int ir, st, stp, ce, dp, ov, bz);
    vec_t v;
    logic [3:0] dd, dpp;
    dd  = d[3:0];
    dpp = dp[3:0];
    v.rst_n = (r != 0);
    v.iv    = (iv != 0);
    v.d     = dd;
    v.ab    = (ab != 0);
    v.ordy  = (ordy != 0);
    v.chk   = (chk != 0);
    v.exp   = {ir != 0, st != 0, stp != 0, ce != 0, dpp, ov != 0, bz != 0};
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual {ir,st,stp,ce,dp,ov,busy}=%b required=%b", name, act, exp);
    end
  endtask

  initial begin
    // mk(rst_n, in_valid, in_data, abort, out_ready, check, ir, st, stp, ce, dp, ov, busy)
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0,0,0));
    // back-to-back codeword
    tbl.push_back(mk(1,1,1,0,0,1, 1,1,0,1,0,0,0));
    tbl.push_back(mk(1,1,2,0,0,1, 1,0,1,1,1,0,1));
    tbl.push_back(mk(1,1,3,0,0,1, 1,0,0,1,2,0,1));
    tbl.push_back(mk(1,1,4,0,0,1, 1,0,0,1,3,0,1));
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,1,4,0,1));
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,1,0,0,1));
    tbl.push_back(mk(1,0,0,0,1,1, 0,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,0,0,0));
    // input gap on cycles 1-2, then long HOLD with ignored in_valid/abort
    tbl.push_back(mk(1,1,1,0,0,1, 1,1,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,1,0,1,0,1));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,1,0,1,0,1));
    tbl.push_back(mk(1,1,2,0,0,1, 1,0,1,1,1,0,1));
    tbl.push_back(mk(1,1,3,0,0,1, 1,0,0,1,2,0,1));
    tbl.push_back(mk(1,1,4,0,0,1, 1,0,0,1,3,0,1));
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,1,4,0,1));
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,1,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,1,1));
    tbl.push_back(mk(1,1,7,0,0,1, 0,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,1,0,1, 0,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,1,1, 0,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,0,0,0));
    // abort with beat 4, restart, then reset during DRAIN
    tbl.push_back(mk(1,1,1,0,0,1, 1,1,0,1,0,0,0));
    tbl.push_back(mk(1,1,2,0,0,1, 1,0,1,1,1,0,1));
    tbl.push_back(mk(1,1,3,0,0,1, 1,0,0,1,2,0,1));
    tbl.push_back(mk(1,1,4,1,0,1, 1,0,0,0,3,0,1));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,3,0,0));
    tbl.push_back(mk(1,1,5,0,0,1, 1,1,0,1,3,0,0));
    tbl.push_back(mk(1,1,6,0,0,1, 1,0,1,1,5,0,1));
    tbl.push_back(mk(1,1,7,0,0,1, 1,0,0,1,6,0,1));
    tbl.push_back(mk(1,1,8,0,0,1, 1,0,0,1,7,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,0,0,0));
    // abort in the first DRAIN cycle
    tbl.push_back(mk(1,1,9,0,0,1, 1,1,0,1,0,0,0));
    tbl.push_back(mk(1,1,10,0,0,1, 1,0,1,1,9,0,1));
    tbl.push_back(mk(1,1,11,0,0,1, 1,0,0,1,10,0,1));
    tbl.push_back(mk(1,1,12,0,0,1, 1,0,0,1,11,0,1));
    tbl.push_back(mk(1,0,0,1,0,1, 0,0,0,0,12,0,1));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,12,0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,12,0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 1,0,0,0,12,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n     = tbl[i].rst_n;
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      abort     = tbl[i].ab;
      out_ready = tbl[i].ordy;
      #1;
      if (tbl[i].chk)
        check($sformatf("vec%0d", i),
              {in_ready, syn_start, syn_start_p, syn_ce, syn_data_p, out_valid, busy}, tbl[i].exp);
    end

    // single-beat, zero-pipeline instance
    @(negedge clk); d2_iv = 1'b1; d2_d = 4'h9; #1;
    check("b1_beat", {d2_ir, d2_st, d2_stp, d2_ce, d2_dp, d2_ov, d2_busy}, 10'b1111_1001_00);
    @(negedge clk); d2_iv = 1'b0; d2_d = 4'h0; d2_ab = 1'b1; #1;
    check("b1_hold", {d2_ir, d2_st, d2_stp, d2_ce, d2_dp, d2_ov, d2_busy}, 10'b0000_0000_11);
    @(negedge clk); d2_ab = 1'b0; d2_or = 1'b1; #1;
    check("b1_hold_abort_ignored", {d2_ir, d2_st, d2_stp, d2_ce, d2_dp, d2_ov, d2_busy}, 10'b0000_0000_11);
    @(negedge clk); d2_or = 1'b0; #1;
    check("b1_idle", {d2_ir, d2_st, d2_stp, d2_ce, d2_dp, d2_ov, d2_busy}, 10'b1000_0000_00);
    @(negedge clk); d2_iv = 1'b1; d2_ab = 1'b1; d2_d = 4'h5; #1;
    check("b1_idle_abort_ignored", {d2_ir, d2_st, d2_stp, d2_ce, d2_dp, d2_ov, d2_busy}, 10'b1111_0101_00);
    @(negedge clk); d2_iv = 1'b0; d2_ab = 1'b0; d2_d = 4'h0; d2_or = 1'b1; #1;
    check("b1_hold2", {d2_ir, d2_st, d2_stp, d2_ce, d2_dp, d2_ov, d2_busy}, 10'b0000_0000_11);
    begin
      int n;
      n = 0;
      while (d2_busy && n < 10) begin
        @(negedge clk); #1;
        n++;
      end
      check("b1_return_idle", {d2_busy, 8'(n), d2_ir}, {1'b0, 8'd1, 1'b1});
    end
    d2_or = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bch_syndrome_sequencer.md
BCH_SYNDROME_SEQUENCER -- requirements
Module: bch_syndrome_sequencer

Interface
REQ-001 Parameter BITS, default 1: input bits per beat; width of the syndrome datapath data input.
REQ-002 Parameter BEATS, default 8: beats per codeword; legal range 1..65535.
REQ-003 Parameter PIPELINE_STAGES, default 0: syndrome datapath pipeline depth; legal range 0..2; any other value is an elaboration error.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  in_data holds a codeword beat.
REQ-007 in_ready  out  1  sequencer accepts the beat; a beat transfers when in_valid and in_ready are both 1.
REQ-008 in_data  in  BITS  codeword beat.
REQ-009 abort  in  1  discards the codeword in progress.
REQ-010 syn_start  out  1  first-beat strobe to the datapath start input.
REQ-011 syn_start_pipelined  out  1  syn_start delayed by one ce-qualified step when PIPELINE_STAGES==2, otherwise equal to syn_start.
REQ-012 syn_ce  out  1  datapath clock enable.
REQ-013 syn_data_pipelined  out  BITS  beat data delayed identically to syn_start_pipelined.
REQ-014 out_valid  out  1  datapath syndromes are final and stable.
REQ-015 out_ready  in  1  downstream has consumed the syndromes.
REQ-016 busy  out  1  state is not IDLE.

Function
REQ-017 States: IDLE, ACCUM, DRAIN, HOLD; a single beat counter of width max(1,$clog2(BEATS)) counts accepted beats.
REQ-018 in_ready is 1 in IDLE and ACCUM and 0 in DRAIN and HOLD.
REQ-019 syn_ce is 1 exactly on the cycles a beat transfers, and on every DRAIN cycle; on all other cycles it is 0, so the datapath holds state across input gaps.
REQ-020 syn_start is 1 only on the cycle the first beat of a codeword transfers (IDLE->ACCUM transfer).
REQ-021 In DRAIN, the value fed into the data delay path is 0.
REQ-022 IDLE plus transfer: the counter becomes 1, and the next state is ACCUM, or is resolved as the last beat (REQ-023) when BEATS==1.
REQ-023 ACCUM plus the transfer of beat BEATS: the next state is DRAIN when PIPELINE_STAGES>0, otherwise HOLD; the counter clears.
REQ-024 DRAIN lasts exactly PIPELINE_STAGES cycles and then goes to HOLD.
REQ-025 out_valid is 1 only in HOLD; a last-beat transfer at cycle T gives out_valid at T+PIPELINE_STAGES+1.
REQ-026 HOLD plus out_ready goes to IDLE on the next cycle; out_valid stays asserted until out_ready is sampled.
REQ-027 abort in ACCUM or DRAIN goes to IDLE, clears the counter, drives syn_ce to 0 that cycle and does not assert out_valid.
REQ-028 abort has priority over a simultaneous transfer, including a last-beat transfer.
REQ-029 abort is ignored in IDLE and HOLD.
REQ-030 The counter wraps only via REQ-023 and never exceeds BEATS.

Reset
REQ-031 While rst_n is 0 at a clock edge: state IDLE, counter 0, delay registers 0, and all outputs except in_ready are 0 (in_ready is 1, as in IDLE).
REQ-032 Reset during any state abandons the codeword with no out_valid pulse; the datapath is re-initialised by the next syn_start.

Structure
REQ-033 State encodings and the derived constants DATA_DLY (1 when PIPELINE_STAGES==2, else 0) and CNT_W reside in a shared BCH sequencer header included by all BCH control blocks.
REQ-034 One sub-module, bch_seq_delay: a ce-qualified delay line of DATA_DLY stages for {start, data}, clearing on reset.
REQ-035 The block contains no GF arithmetic; it drives only the datapath control inputs.

Verification (BITS=4, BEATS=4, PIPELINE_STAGES=2)
REQ-036 Four back-to-back beats 0x1,0x2,0x3,0x4 from cycle 0 -> syn_start at cycle 0, syn_start_pipelined at cycle 1, syn_ce high cycles 0-5, out_valid at cycle 6.
REQ-037 Same beats with in_valid low on cycles 1-2 -> syn_ce low on cycles 1-2, counter unchanged, out_valid 2 cycles later than in REQ-036.
REQ-038 out_ready held 0 for 5 cycles in HOLD -> out_valid held, in_ready 0, syn_ce 0; out_ready=1 -> IDLE next cycle with in_ready=1.
REQ-039 abort together with beat 4 -> no DRAIN, no out_valid, IDLE next cycle; the next codeword starts with syn_start.
REQ-040 rst_n=0 during DRAIN -> IDLE next cycle with all outputs at reset values and no out_valid.
REQ-041 BEATS=1 and PIPELINE_STAGES=0, single beat at cycle 0 -> syn_start and syn_ce at cycle 0, out_valid at cycle 1.
